fpadd_single: RTL and testbench
===============================

FPADD_SINGLE -- requirements
Module: fpadd_single

Interface
REQ-001 Parameters: none; all widths are fixed at IEEE-754 binary32.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 reset  input  1  synchronous, active-high reset; sampled on the rising edge of clk.
REQ-004 reg_A  input  32  operand A, IEEE-754 single precision (sign[31], exp[30:23], frac[22:0]).
REQ-005 reg_B  input  32  operand B, same format as reg_A.
REQ-006 result  output  32  registered sum A+B, IEEE-754 single precision.

Function
REQ-007 Two-stage pipeline: edge 1 captures reg_A/reg_B into input registers; the combinational adder computes on these registers; edge 2 captures the sum into the result register.
REQ-008 Latency is exactly 2 rising edges from operand application to valid result; a new operand pair may be accepted every cycle (throughput 1/cycle); there is no handshake.
REQ-009 Datapath: unpack with hidden bit; swap so the larger magnitude is first; right-align the smaller operand by the exponent difference, keeping guard, round and sticky bits (sticky = OR of all shifted-out bits; shifts of 26 or more give sticky only).
REQ-010 Effective add when the signs are equal, otherwise subtract the smaller magnitude from the larger; the result sign is the sign of the larger-magnitude operand.
REQ-011 Normalize: on carry-out, shift right 1 with exponent+1 (fold the shifted bit into sticky); on cancellation, shift left by the leading-zero count and decrease the exponent.
REQ-012 Rounding mode is round-to-nearest-even using guard/round/sticky; a mantissa overflow from rounding renormalizes with exponent+1.
REQ-013 Subnormal inputs (exp=0) are treated as zero with the same sign; a result whose exponent underflows below 1 is flushed to zero with the computed sign.
REQ-014 A result exponent of 255 or more after rounding gives infinity with the computed sign (0x7F800000 / 0xFF800000).
REQ-015 Exact cancellation (x + -x) gives +0 (0x00000000); +0 + +0 gives +0; -0 + -0 gives -0 (0x80000000); mixed-sign zeros give +0.
REQ-016 Zero plus a nonzero x returns x bit-exactly.
REQ-017 A NaN on either input returns the canonical quiet NaN 0x7FC00000; +inf + -inf returns 0x7FC00000; inf + finite returns that inf; inf + inf of the same sign returns that inf.
REQ-018 result is a pure register output with no combinational path from inputs to output.

Reset
REQ-019 While reset is high at a rising edge, the input registers and the result register load 0x00000000.
REQ-020 result reads 0x00000000 from the first edge with reset high; reset asserted mid-operation discards all in-flight operands.
REQ-021 After reset deasserts, the first valid result appears 2 edges after operands are applied.

Structure
REQ-022 Shared package fpadd_pkg holds the constants EXP_W=8, FRAC_W=23, BIAS=127, EXP_MAX=255, QNAN=32'h7FC00000, POS_INF, NEG_INF, and an unpacked-float struct type (sign, exp, 24-bit mantissa).
REQ-023 One sub-module, fpadd_lzc, is a combinational leading-zero counter over the 27-bit normalized-sum field, used in the normalize stage; all other logic lives in fpadd_single.

Verification
REQ-024 3F800000 + 3F800000 -> 40000000 (1+1=2), checked exactly 2 edges after application.
REQ-025 3FC00000 + 40100000 -> 40700000 (1.5+2.25=3.75); 40400000 + BF800000 -> 40000000 (3-1=2).
REQ-026 3F800000 + BF800000 -> 00000000; 80000000 + 80000000 -> 80000000.
REQ-027 Rounding ties: 3F800000 + 33800000 -> 3F800000 (tie, already even); 3F800001 + 33800000 -> 3F800002 (tie, round up to even).
REQ-028 7F7FFFFF + 7F7FFFFF -> 7F800000; 7F800000 + FF800000 -> 7FC00000; 7FC00000 + 3F800000 -> 7FC00000.
REQ-029 Back-to-back operand pairs on consecutive cycles each produce the correct result 2 edges later; reset asserted with operands pending gives result 00000000 on the next edge, and no stale result appears after reset releases.

Source files
------------

// File: rtl/fpadd_pkg.sv
// rtl/fpadd_pkg.sv - shared binary32 constants, unpacked-float type and unpack helper
package fpadd_pkg;

    localparam int EXP_W   = 8;
    localparam int FRAC_W  = 23;
    localparam int BIAS    = 127;
    localparam int EXP_MAX = 255;

    localparam logic [31:0] QNAN    = 32'h7FC00000;
    localparam logic [31:0] POS_INF = 32'h7F800000;
    localparam logic [31:0] NEG_INF = 32'hFF800000;

    typedef struct packed {
        logic              sign;
        logic [EXP_W-1:0]  exp;
        logic [FRAC_W:0]   mant;
    } fp_unpacked_t;

    // Subnormals unpack with a zero mantissa so they behave as signed zero.
    function automatic fp_unpacked_t fp_unpack(input logic [31:0] x);
        fp_unpacked_t u;
        u.sign = x[31];
        u.exp  = x[30:23];
        u.mant = (x[30:23] == 8'd0) ? 24'd0 : {1'b1, x[22:0]};
        return u;
    endfunction

endpackage

// File: rtl/fpadd_lzc.sv
// rtl/fpadd_lzc.sv - leading-zero counter over the 27-bit normalize field
module fpadd_lzc (
    input  logic [26:0] value_i,
    output logic [4:0]  count_o
);

    always_comb begin
        count_o = 5'd27;
        for (int i = 0; i < 27; i++) begin
            if (value_i[i]) count_o = 5'(26 - i);
        end
    end

endmodule

// File: rtl/fpadd_single.sv
// rtl/fpadd_single.sv - two-stage binary32 adder, round-to-nearest-even, flush-to-zero
module fpadd_single
    import fpadd_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] reg_A,
    input  logic [31:0] reg_B,
    output logic [31:0] result
);

    logic [31:0]  a_q, b_q, result_q, result_d;
    fp_unpacked_t ua, ub, big;
    logic [7:0]   small_exp, exp_diff;
    logic [23:0]  small_mant;
    logic         swap, eff_sub, align_sticky;
    logic         a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
    logic [26:0]  big_m, small_m, shifted_m, norm_m;
    logic [27:0]  sum;
    logic [4:0]   lz;
    logic [9:0]   norm_e, final_e;
    logic [24:0]  rnd_m;
    logic [22:0]  frac_out;
    logic         round_up, underflow, overflow;

    always_ff @(posedge clk) begin
        if (reset) begin
            a_q      <= 32'h0;
            b_q      <= 32'h0;
            result_q <= 32'h0;
        end else begin
            a_q      <= reg_A;
            b_q      <= reg_B;
            result_q <= result_d;
        end
    end

    assign result = result_q;

    // Align: larger magnitude first, smaller shifted right with g/r/sticky.
    always_comb begin
        ua         = fp_unpack(a_q);
        ub         = fp_unpack(b_q);
        swap       = {ub.exp, ub.mant} > {ua.exp, ua.mant};
        big        = swap ? ub : ua;
        small_exp  = swap ? ua.exp : ub.exp;
        small_mant = swap ? ua.mant : ub.mant;
        eff_sub    = ua.sign ^ ub.sign;
        exp_diff   = big.exp - small_exp;
        big_m      = {big.mant, 3'b000};
        small_m    = {small_mant, 3'b000};
        align_sticky = 1'b0;
        if (exp_diff >= 8'd26) begin
            shifted_m = 27'd1;
        end else begin
            shifted_m    = small_m >> exp_diff;
            align_sticky = |(small_m & ~(27'h7FFFFFF << exp_diff));
            shifted_m[0] = shifted_m[0] | align_sticky;
        end
        sum = eff_sub ? ({1'b0, big_m} - {1'b0, shifted_m})
                      : ({1'b0, big_m} + {1'b0, shifted_m});
    end

    fpadd_lzc u_lzc (
        .value_i (sum[26:0]),
        .count_o (lz)
    );

    // Normalize, round, then resolve special operands by priority.
    always_comb begin
        if (sum[27]) begin
            norm_m    = sum[27:1];
            norm_m[0] = sum[1] | sum[0];
            norm_e    = {2'b00, big.exp} + 10'd1;
        end else begin
            norm_m = sum[26:0] << lz;
            norm_e = {2'b00, big.exp} - {5'b00000, lz};
        end
        round_up  = norm_m[2] & (norm_m[1] | norm_m[0] | norm_m[3]);
        rnd_m     = {1'b0, norm_m[26:3]} + {24'd0, round_up};
        final_e   = rnd_m[24] ? norm_e + 10'd1 : norm_e;
        frac_out  = rnd_m[24] ? rnd_m[23:1] : rnd_m[22:0];
        underflow = final_e[9] || (final_e == 10'd0);
        overflow  = !final_e[9] && (final_e >= 10'(EXP_MAX));

        a_nan  = (a_q[30:23] == 8'hFF) && (a_q[22:0] != 23'd0);
        b_nan  = (b_q[30:23] == 8'hFF) && (b_q[22:0] != 23'd0);
        a_inf  = (a_q[30:23] == 8'hFF) && (a_q[22:0] == 23'd0);
        b_inf  = (b_q[30:23] == 8'hFF) && (b_q[22:0] == 23'd0);
        a_zero = (a_q[30:23] == 8'd0);
        b_zero = (b_q[30:23] == 8'd0);

        result_d = {big.sign, final_e[7:0], frac_out};
        if (a_nan || b_nan)           result_d = QNAN;
        else if (a_inf && b_inf)      result_d = (a_q[31] != b_q[31]) ? QNAN : a_q;
        else if (a_inf)               result_d = a_q;
        else if (b_inf)               result_d = b_q;
        else if (a_zero && b_zero)    result_d = {a_q[31] & b_q[31], 31'd0};
        else if (a_zero)              result_d = b_q;
        else if (b_zero)              result_d = a_q;
        else if (sum == 28'd0)        result_d = 32'h0;
        else if (underflow)           result_d = {big.sign, 31'd0};
        else if (overflow)            result_d = big.sign ? NEG_INF : POS_INF;
    end

endmodule

// File: tb/tb_fpadd_single.sv
// tb/tb_fpadd_single.sv - directed and randomized checks of fpadd_single against an exact-arithmetic model
module tb_fpadd_single;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] reg_A, reg_B, result;
    int          checks = 0;
    int          failures = 0;
    logic [31:0] exp_q[$];
    logic [31:0] specials [6] = '{32'h00000000, 32'h80000000, 32'h7F800000,
                                  32'hFF800000, 32'h7FC00001, 32'h00012345};

    fpadd_single dut (
        .clk    (clk),
        .reset  (reset),
        .reg_A  (reg_A),
        .reg_B  (reg_B),
        .result (result)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
        end
    endtask

    // Sum taken exactly as integers scaled by 2^149, then rounded once to 24 bits.
    function automatic logic [31:0] ref_add(input logic [31:0] a, input logic [31:0] b);
        logic [299:0] ma, mb, mag, low;
        logic [24:0]  keep;
        logic         sgn, g, st;
        int           p, sh, e;
        if ((a[30:23] == 8'hFF && a[22:0] != 0) || (b[30:23] == 8'hFF && b[22:0] != 0))
            return 32'h7FC00000;
        if (a[30:23] == 8'hFF && b[30:23] == 8'hFF)
            return (a[31] != b[31]) ? 32'h7FC00000 : a;
        if (a[30:23] == 8'hFF) return a;
        if (b[30:23] == 8'hFF) return b;
        if (a[30:23] == 0 && b[30:23] == 0) return {a[31] & b[31], 31'd0};
        if (a[30:23] == 0) return b;
        if (b[30:23] == 0) return a;
        ma = {276'd0, 1'b1, a[22:0]};
        mb = {276'd0, 1'b1, b[22:0]};
        ma = ma << (int'(a[30:23]) - 1);
        mb = mb << (int'(b[30:23]) - 1);
        if (a[31] == b[31]) begin mag = ma + mb; sgn = a[31]; end
        else if (ma > mb)   begin mag = ma - mb; sgn = a[31]; end
        else if (mb > ma)   begin mag = mb - ma; sgn = b[31]; end
        else return 32'h0;
        p = 0;
        for (int i = 0; i < 300; i++) if (mag[i]) p = i;
        e = p - 22;
        if (e < 1) return {sgn, 31'd0};
        sh   = p - 23;
        keep = 25'(mag >> sh);
        g = 1'b0;
        st = 1'b0;
        if (sh > 0) begin
            g   = mag[sh-1];
            low = mag & ((300'd1 << (sh - 1)) - 300'd1);
            st  = |low;
        end
        if (g && (st || keep[0])) keep = keep + 25'd1;
        if (keep[24]) begin keep = keep >> 1; e++; end
        if (e >= 255) return {sgn, 8'hFF, 23'd0};
        return {sgn, 8'(e), keep[22:0]};
    endfunction

    function automatic logic [31:0] rand_normal(input int e);
        return {1'($urandom), 8'(e), 23'($urandom)};
    endfunction

    task automatic check_pair(input string tag, input logic [31:0] a, input logic [31:0] b,
                              input logic [31:0] exp);
        @(negedge clk);
        reg_A = a;
        reg_B = b;
        @(negedge clk);
        @(negedge clk);
        check(tag, result, exp);
    endtask

    initial begin
        logic [31:0] a, b, t;
        int          ea, eb, mode;

        reset = 1'b1;
        reg_A = 32'h3F800000;
        reg_B = 32'h3F800000;
        @(negedge clk);
        check("reset_first_edge", result, 32'h0);
        @(negedge clk);
        check("reset_held", result, 32'h0);

        reset = 1'b0;
        @(negedge clk);
        check("latency_one_edge", result, 32'h0);
        @(negedge clk);
        check("one_plus_one", result, 32'h40000000);

        check_pair("add_1p5_2p25", 32'h3FC00000, 32'h40100000, 32'h40700000);
        check_pair("sub_3_1", 32'h40400000, 32'hBF800000, 32'h40000000);
        check_pair("cancel", 32'h3F800000, 32'hBF800000, 32'h00000000);
        check_pair("negzero_negzero", 32'h80000000, 32'h80000000, 32'h80000000);
        check_pair("mixed_zeros", 32'h80000000, 32'h00000000, 32'h00000000);
        check_pair("tie_even", 32'h3F800000, 32'h33800000, 32'h3F800000);
        check_pair("tie_round_up", 32'h3F800001, 32'h33800000, 32'h3F800002);
        check_pair("overflow_inf", 32'h7F7FFFFF, 32'h7F7FFFFF, 32'h7F800000);
        check_pair("inf_minus_inf", 32'h7F800000, 32'hFF800000, 32'h7FC00000);
        check_pair("nan_in", 32'h7FC00000, 32'h3F800000, 32'h7FC00000);
        check_pair("zero_plus_x", 32'h00000000, 32'hC0490FDB, 32'hC0490FDB);
        check_pair("subnormal_plus_x", 32'h40490FDB, 32'h80001234, 32'h40490FDB);
        check_pair("neginf_plus_finite", 32'h3F800000, 32'hFF800000, 32'hFF800000);
        check_pair("underflow_flush", 32'h00800001, 32'h80800000, 32'h00000000);

        // Back-to-back random pairs; each result is checked two edges after it is applied.
        for (int i = 0; i < 400; i++) begin
            ea = ($urandom_range(0, 3) == 0)
                 ? (($urandom_range(0, 1) == 0) ? int'($urandom_range(1, 6))
                                                : int'($urandom_range(249, 254)))
                 : int'($urandom_range(1, 254));
            a = rand_normal(ea);
            mode = int'($urandom_range(0, 9));
            case (mode)
                0: b = $urandom();
                1: b = specials[$urandom_range(0, 5)];
                2: b = {~a[31], a[30:0]} ^ {9'd0, 23'($urandom_range(0, 3))};
                default: begin
                    eb = ea + int'($urandom_range(0, 8)) - 4;
                    if (eb < 1) eb = 1;
                    if (eb > 254) eb = 254;
                    b = rand_normal(eb);
                end
            endcase
            if ($urandom_range(0, 1) == 1) begin t = a; a = b; b = t; end
            @(negedge clk);
            if (i >= 2) check($sformatf("rand%0d", i - 2), result, exp_q.pop_front());
            reg_A = a;
            reg_B = b;
            exp_q.push_back(ref_add(a, b));
        end
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check($sformatf("rand_drain%0d", i), result, exp_q.pop_front());
        end

        // Reset with an operand pair pending must discard it.
        reg_A = 32'h40400000;
        reg_B = 32'h40400000;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("reset_mid_op", result, 32'h0);
        reset = 1'b0;
        reg_A = 32'h0;
        reg_B = 32'h0;
        @(negedge clk);
        check("no_stale_1", result, 32'h0);
        @(negedge clk);
        check("no_stale_2", result, 32'h0);
        check_pair("post_reset_add", 32'h3FC00000, 32'h40100000, 32'h40700000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
